or16: RTL and testbench



---
 rtl/or16.sv | 91 +++++++++
 tb/tb_or16.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/or16.sv
// 16-bit bitwise OR with a combinational result, a registered copy with popcount/flags,
// and an optional sticky OR accumulator enabled by defining OR16_ACC_EN.
module or16 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        in_valid,
   input  logic        acc_clr,
   output logic [15:0] out,
   output logic [15:0] out_q,
   output logic        out_valid,
   output logic [4:0]  ones_q,
   output logic        all_ones_q,
   output logic        zero_q,
   output logic [15:0] acc_q
);

   localparam int unsigned W      = 16;
   localparam int unsigned CNT_W  = 5;

   logic [W-1:0]     or_c;
   logic [CNT_W-1:0] ones_c;
   logic             all_ones_c;
   logic             zero_c;

   // Zero-latency primary result; also tracks inputs while in reset.
   assign out = or_c;

   // OR value plus its exact population count and extreme-value flags.
   always_comb begin
      or_c   = a | b;
      ones_c = '0;
      for (int unsigned i = 0; i < W; i++) begin
         ones_c = ones_c + CNT_W'(or_c[i]);
      end
      all_ones_c = (or_c == {W{1'b1}});
      zero_c     = (or_c == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
      end
   end

   // Result and flags load only on a qualified edge and otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q      <= '0;
         ones_q     <= '0;
         all_ones_q <= 1'b0;
         zero_q     <= 1'b0;
      end else if (in_valid) begin
         out_q      <= or_c;
         ones_q     <= ones_c;
         all_ones_q <= all_ones_c;
         zero_q     <= zero_c;
      end
   end

`ifdef OR16_ACC_EN
   logic [W-1:0] acc_d;

   // Clear has priority; clear with a capture restarts the accumulation from this value.
   always_comb begin
      acc_d = acc_q;
      if (acc_clr) begin
         acc_d = in_valid ? or_c : '0;
      end else if (in_valid) begin
         acc_d = acc_q | or_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end
`else
   logic unused_acc_clr;

   assign unused_acc_clr = acc_clr;
   assign acc_q          = '0;
`endif

endmodule

// File: tb/tb_or16.sv
// Directed self-checking bench for or16; accumulator checks follow OR16_ACC_EN.
module tb_or16;

   logic        clk;
   logic        rst_n;
   logic [15:0] a;
   logic [15:0] b;
   logic        in_valid;
   logic        acc_clr;
   logic [15:0] out;
   logic [15:0] out_q;
   logic        out_valid;
   logic [4:0]  ones_q;
   logic        all_ones_q;
   logic        zero_q;
   logic [15:0] acc_q;

   int checks;
   int errors;

   or16 dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .a          (a),
      .b          (b),
      .in_valid   (in_valid),
      .acc_clr    (acc_clr),
      .out        (out),
      .out_q      (out_q),
      .out_valid  (out_valid),
      .ones_q     (ones_q),
      .all_ones_q (all_ones_q),
      .zero_q     (zero_q),
      .acc_q      (acc_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_comb();
      logic [15:0] va [6];
      logic [15:0] vb [6];
      logic [15:0] ve [6];
      va[0] = 16'h0000; vb[0] = 16'h0000; ve[0] = 16'h0000;
      va[1] = 16'h0000; vb[1] = 16'hFFFF; ve[1] = 16'hFFFF;
      va[2] = 16'hFFFF; vb[2] = 16'hFFFF; ve[2] = 16'hFFFF;
      va[3] = 16'hAAAA; vb[3] = 16'h5555; ve[3] = 16'hFFFF;
      va[4] = 16'h3CC3; vb[4] = 16'h0FF0; ve[4] = 16'h3FF3;
      va[5] = 16'h1234; vb[5] = 16'h9876; ve[5] = 16'h9A76;
      for (int i = 0; i < 6; i++) begin
         a = va[i];
         b = vb[i];
         #1;
         checks++;
         if (out !== ve[i]) begin
            errors++;
            $display("FAIL comb_%0d out=%h expected=%h", i, out, ve[i]);
         end
      end
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      in_valid = 1'b1;
      a        = 16'hFFFF;
      b        = 16'h0000;
      @(negedge clk);
      checks++;
      if ({out_q, ones_q, all_ones_q, zero_q, out_valid, acc_q} !== 39'd0) begin
         errors++;
         $display("FAIL reset_regs out_q=%h ones=%0d all=%b zero=%b valid=%b acc=%h expected all 0",
                  out_q, ones_q, all_ones_q, zero_q, out_valid, acc_q);
      end
      checks++;
      if (out !== 16'hFFFF) begin
         errors++;
         $display("FAIL reset_out out=%h expected=ffff", out);
      end
      rst_n    = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({out_q, ones_q, all_ones_q, zero_q, out_valid, acc_q} !== 39'd0) begin
         errors++;
         $display("FAIL post_reset_idle out_q=%h ones=%0d valid=%b acc=%h expected 0",
                  out_q, ones_q, out_valid, acc_q);
      end
   endtask

   task automatic test_capture();
      a        = 16'h1234;
      b        = 16'h9876;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      a        = 16'h0000;
      b        = 16'h0000;
      checks++;
      if (out_q !== 16'h9A76 || ones_q !== 5'd9 || all_ones_q !== 1'b0 ||
          zero_q !== 1'b0 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL capture out_q=%h ones=%0d all=%b zero=%b valid=%b expected 9a76/9/0/0/1",
                  out_q, ones_q, all_ones_q, zero_q, out_valid);
      end
      @(negedge clk);
      checks++;
      if (out_q !== 16'h9A76 || ones_q !== 5'd9 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL capture_hold out_q=%h ones=%0d valid=%b expected 9a76/9/0",
                  out_q, ones_q, out_valid);
      end
   endtask

   task automatic test_flags();
      a        = 16'hAAAA;
      b        = 16'h5555;
      in_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (ones_q !== 5'd16 || all_ones_q !== 1'b1 || zero_q !== 1'b0 || out_q !== 16'hFFFF) begin
         errors++;
         $display("FAIL flags_full out_q=%h ones=%0d all=%b zero=%b expected ffff/16/1/0",
                  out_q, ones_q, all_ones_q, zero_q);
      end
      a = 16'h0000;
      b = 16'h0000;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (ones_q !== 5'd0 || all_ones_q !== 1'b0 || zero_q !== 1'b1 || out_q !== 16'h0000) begin
         errors++;
         $display("FAIL flags_zero out_q=%h ones=%0d all=%b zero=%b expected 0000/0/0/1",
                  out_q, ones_q, all_ones_q, zero_q);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] va [3];
      logic [15:0] vb [3];
      logic [15:0] ve [3];
      logic [4:0]  vn [3];
      va[0] = 16'h0001; vb[0] = 16'h0002; ve[0] = 16'h0003; vn[0] = 5'd2;
      va[1] = 16'h00F0; vb[1] = 16'h0F00; ve[1] = 16'h0FF0; vn[1] = 5'd8;
      va[2] = 16'h8000; vb[2] = 16'h0001; ve[2] = 16'h8001; vn[2] = 5'd2;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a = va[i];
         b = vb[i];
         @(negedge clk);
         checks++;
         if (out_q !== ve[i] || ones_q !== vn[i] || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_%0d out_q=%h ones=%0d valid=%b expected %h/%0d/1",
                     i, out_q, ones_q, out_valid, ve[i], vn[i]);
         end
      end
      in_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_acc();
      logic [15:0] exp_acc [5];
`ifdef OR16_ACC_EN
      exp_acc[0] = 16'h0000; exp_acc[1] = 16'h000F; exp_acc[2] = 16'h01FF;
      exp_acc[3] = 16'h8000; exp_acc[4] = 16'h0000;
`else
      for (int i = 0; i < 5; i++) exp_acc[i] = 16'h0000;
`endif
      // Step 0: clear alone
      acc_clr = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (acc_q !== exp_acc[0]) begin
         errors++; $display("FAIL acc_clear_init acc=%h expected=%h", acc_q, exp_acc[0]);
      end
      acc_clr = 1'b0; in_valid = 1'b1; a = 16'h000F; b = 16'h0000;
      @(negedge clk);
      checks++;
      if (acc_q !== exp_acc[1]) begin
         errors++; $display("FAIL acc_first acc=%h expected=%h", acc_q, exp_acc[1]);
      end
      a = 16'h00F0; b = 16'h0100;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (acc_q !== exp_acc[2]) begin
         errors++; $display("FAIL acc_second acc=%h expected=%h", acc_q, exp_acc[2]);
      end
      @(negedge clk);
      checks++;
      if (acc_q !== exp_acc[2]) begin
         errors++; $display("FAIL acc_hold acc=%h expected=%h", acc_q, exp_acc[2]);
      end
      acc_clr = 1'b1; in_valid = 1'b1; a = 16'h8000; b = 16'h0000;
      @(negedge clk);
      checks++;
      if (acc_q !== exp_acc[3]) begin
         errors++; $display("FAIL acc_clr_load acc=%h expected=%h", acc_q, exp_acc[3]);
      end
      in_valid = 1'b0;
      @(negedge clk);
      acc_clr = 1'b0;
      checks++;
      if (acc_q !== exp_acc[4]) begin
         errors++; $display("FAIL acc_clr_only acc=%h expected=%h", acc_q, exp_acc[4]);
      end
   endtask

   task automatic test_async_reset();
      logic [15:0] exp_before;
`ifdef OR16_ACC_EN
      exp_before = 16'h00FF;
`else
      exp_before = 16'h0000;
`endif
      in_valid = 1'b1; a = 16'h00F0; b = 16'h000F;
      @(negedge clk);
      a = 16'h0C00; b = 16'h0000;
      checks++;
      if (acc_q !== exp_before || out_q !== 16'h00FF) begin
         errors++;
         $display("FAIL async_preload acc=%h out_q=%h expected %h/00ff", acc_q, out_q, exp_before);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (acc_q !== 16'h0000 || out_q !== 16'h0000 || out_valid !== 1'b0 || ones_q !== 5'd0) begin
         errors++;
         $display("FAIL async_reset acc=%h out_q=%h valid=%b ones=%0d expected all 0",
                  acc_q, out_q, out_valid, ones_q);
      end
      checks++;
      if (out !== 16'h0C00) begin
         errors++; $display("FAIL async_reset_out out=%h expected=0c00", out);
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b1;
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst_n    = 1'b0;
      a        = '0;
      b        = '0;
      in_valid = 1'b0;
      acc_clr  = 1'b0;
      test_comb();
      test_reset();
      test_capture();
      test_flags();
      test_back_to_back();
      test_acc();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
